// File: rtl/vga_sync_decoder.sv
// Rebuilds pixel_x/pixel_y, video_on, frame_start and lock from active-low hsync/vsync.
// Latency: outputs are registered, 1 clk after the sync sample.
// Backpressure: none; one sample is consumed every clock. Option VGA_DEC_ERRCNT_EN adds err_count.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
`ifdef VGA_DEC_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_AFTER = 10'(V_ACTIVE + V_FP + 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] good_cnt, good_cnt_nxt;
    logic       hs_q, vs_q;
    logic       vs_seen, vs_seen_nxt;
    logic       hs_edge, vs_edge;
    logic [9:0] h_p, v_p, x_nxt, y_nxt;
    logic       viol, lock_nxt;

    always_comb begin
        hs_edge = hs_q & ~hsync_in;
        vs_edge = vs_q & ~vsync_in;

        h_p = (pixel_x == H_LAST) ? 10'd0 : pixel_x + 10'd1;
        v_p = pixel_y;
        if (pixel_x == H_LAST) begin
            v_p = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
        end

        x_nxt = hs_edge ? HS_START : h_p;
        y_nxt = vs_edge ? VS_START : v_p;

        // vs_seen remembers whether the vsync edge arrived once the row reached VS_START
        vs_seen_nxt = vs_seen;
        if (vs_edge) begin
            vs_seen_nxt = 1'b1;
        end else if (v_p == VS_START && pixel_y != VS_START) begin
            vs_seen_nxt = 1'b0;
        end

        viol = 1'b0;
        if (state != SEARCH) begin
            viol = (hs_edge && h_p != HS_START)
                || (!hs_edge && h_p == HS_START)
                || (vs_edge && v_p != VS_START)
                || (v_p == VS_AFTER && pixel_y == VS_START && !vs_seen);
        end

        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        case (state)
            SEARCH: begin
                if (vs_edge) begin
                    state_nxt    = VERIFY;
                    good_cnt_nxt = 4'd0;
                end
            end
            VERIFY: begin
                if (viol) begin
                    state_nxt = SEARCH;
                end else if (vs_edge) begin
                    good_cnt_nxt = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 == LOCK_N) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (viol) begin
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase

        lock_nxt = (state_nxt == LOCKED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SEARCH;
            good_cnt    <= 4'd0;
            vs_seen     <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_cnt_nxt;
            vs_seen     <= vs_seen_nxt;
            hs_q        <= hsync_in;
            vs_q        <= vsync_in;
            pixel_x     <= x_nxt;
            pixel_y     <= y_nxt;
            video_on    <= lock_nxt && (x_nxt < H_ACT) && (y_nxt < V_ACT);
            frame_start <= lock_nxt && (x_nxt == 10'd0) && (y_nxt == 10'd0);
            locked      <= lock_nxt;
            sync_err    <= viol;
        end
    end

`ifdef VGA_DEC_ERRCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= 8'd0;
        end else if (viol && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a shrunken 32x20 raster: stimulus pushes
// model expectations, a monitor pops and compares every registered output.
module tb_vga_sync_decoder;

    localparam int HA = 16, HF = 4, HSY = 6, HB = 6;
    localparam int VA = 12, VF = 2, VSY = 2, VB = 4;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int HS = HA + HF;
    localparam int VS = VA + VF;
    localparam int LOCK = 2;
    localparam int FRAME = HT * VT;
    localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       fs;
        logic       lk;
        logic       err;
        logic [7:0] ec;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       frame_start;
    logic       locked;
    logic       sync_err;
`ifdef VGA_DEC_ERRCNT_EN
    logic [7:0] err_count;
`endif

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .LOCK_FRAMES(LOCK)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .video_on(video_on),
        .frame_start(frame_start),
        .locked(locked),
        .sync_err(sync_err)
`ifdef VGA_DEC_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_samp = 0;
    exp_t exp_q[$];

    // reference model state (plain integers, raster arithmetic)
    int m_x, m_y, m_st, m_good, m_ec;
    bit m_seen, m_hq, m_vq;

    // generator state and one-shot fault requests
    int gen_h = 0, gen_v = 0, last_h = 0, last_v = 0;
    bit f_early = 0, f_droph = 0, f_supv = 0, f_glitch = 0;
    int glitch_h = 0;
    int von_cnt = 0, fs_cnt = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic void model_step(input bit rst, input bit hs, input bit vs);
        exp_t e;
        bit   hf, vf, bad, lk;
        int   nx, ny;
        e = '0;
        if (!rst) begin
            m_x = 0; m_y = 0; m_st = M_SEARCH; m_good = 0; m_ec = 0;
            m_seen = 0; m_hq = 1; m_vq = 1;
        end else begin
            hf  = m_hq && !hs;
            vf  = m_vq && !vs;
            nx  = (m_x + 1) % HT;
            ny  = (nx == 0) ? (m_y + 1) % VT : m_y;
            bad = (m_st != M_SEARCH) &&
                  ((hf != (nx == HS)) || (vf && ny != VS) ||
                   (!m_seen && m_y == VS && ny == VS + 1));
            if (vf) m_seen = 1;
            else if (ny == VS && m_y != VS) m_seen = 0;
            if (bad) begin
                m_st = M_SEARCH;
                if (m_ec < 255) m_ec++;
            end else if (vf) begin
                if (m_st == M_SEARCH) begin
                    m_st = M_VERIFY;
                    m_good = 0;
                end else if (m_st == M_VERIFY) begin
                    m_good++;
                    if (m_good == LOCK) m_st = M_LOCKED;
                end
            end
            m_x = hf ? HS : nx;
            m_y = vf ? VS : ny;
            m_hq = hs;
            m_vq = vs;
            lk = (m_st == M_LOCKED);
            e.x   = 10'(m_x);
            e.y   = 10'(m_y);
            e.lk  = lk;
            e.von = lk && m_x < HA && m_y < VA;
            e.fs  = lk && m_x == 0 && m_y == 0;
            e.err = bad;
            e.ec  = 8'(m_ec);
        end
        exp_q.push_back(e);
    endfunction

    // called at a negedge; returns at the next negedge
    task automatic drive(input bit rst, input bit hs, input bit vs);
        reset_n  = rst;
        hsync_in = hs;
        vsync_in = vs;
        model_step(rst, hs, vs);
        @(negedge clk);
    endtask

    task automatic gen_step(input bit rst);
        bit hs, vs;
        hs = !(gen_h >= HS && gen_h < HS + HSY);
        vs = !(gen_v >= VS && gen_v < VS + VSY);
        if (f_early && gen_h == HS - 1) begin
            hs = 0;
            f_early = 0;
        end
        if (f_droph && gen_h >= HS && gen_h < HS + HSY) begin
            hs = 1;
            if (gen_h == HS + HSY - 1) f_droph = 0;
        end
        if (f_supv) begin
            vs = 1;
            if (gen_v == VS + VSY - 1 && gen_h == HT - 1) f_supv = 0;
        end
        if (f_glitch && gen_h == glitch_h) begin
            hs = 0;
            f_glitch = 0;
        end
        drive(rst, hs, vs);
        last_h = gen_h;
        last_v = gen_v;
        gen_h = (gen_h + 1) % HT;
        if (gen_h == 0) gen_v = (gen_v + 1) % VT;
    endtask

    task automatic run_gen(input int n);
        for (int i = 0; i < n; i++) gen_step(1);
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < FRAME + 2 && !(gen_h == h && gen_v == v); i++) gen_step(1);
    endtask

    // monitor / scoreboard
    initial begin
        exp_t e, act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act.x   = pixel_x;
                act.y   = pixel_y;
                act.von = video_on;
                act.fs  = frame_start;
                act.lk  = locked;
                act.err = sync_err;
`ifdef VGA_DEC_ERRCNT_EN
                act.ec  = err_count;
`else
                act.ec  = 8'd0;
                e.ec    = 8'd0;
`endif
                von_cnt += int'(video_on);
                fs_cnt  += int'(frame_start);
                n_cmp++;
                if (act != e) begin
                    n_fail++;
                    $display("FAIL outputs sample %0d: got x=%0d y=%0d von=%0b fs=%0b lk=%0b err=%0b ec=%0d, expected x=%0d y=%0d von=%0b fs=%0b lk=%0b err=%0b ec=%0d",
                             n_samp, act.x, act.y, act.von, act.fs, act.lk, act.err, act.ec,
                             e.x, e.y, e.von, e.fs, e.lk, e.err, e.ec);
                end
                n_samp++;
            end
        end
    end

    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        reset_n  = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        @(negedge clk);
        repeat (4) drive(0, 1, 1);
        check("reset_locked", int'(locked), 0);
        check("reset_pixel_x", int'(pixel_x), 0);

        // clean raster from (0,0): first vsync edge at sample VS*HT, lock LOCK frames later
        run_gen(VS * HT + LOCK * FRAME);
        check("lock_not_early", int'(locked), 0);
        run_gen(1);
        check("lock_on_time", int'(locked), 1);
        check("pos_x_delay1", int'(pixel_x), last_h);
        check("pos_y_delay1", int'(pixel_y), last_v);

        // one full frame while locked
        von_cnt = 0;
        fs_cnt  = 0;
        run_gen(FRAME);
        check("video_on_per_frame", von_cnt, HA * VA);
        check("frame_start_per_frame", fs_cnt, 1);

        // hsync edge one clock early
        run_to(HS - 1, 3);
        f_early = 1;
        run_gen(1);
        check("early_h_err", int'(sync_err), 1);
        check("early_h_unlock", int'(locked), 0);
        run_gen(4 * FRAME);
        check("early_h_relock", int'(locked), 1);

        // missing vsync pulse: caught when the row would pass VS_START
        run_to(0, 0);
        f_supv = 1;
        run_to(1, VS + 1);
        check("supv_err", int'(sync_err), 1);
        check("supv_unlock", int'(locked), 0);
        run_gen(4 * FRAME);
        check("supv_relock", int'(locked), 1);

        // asynchronous reset mid-line
        run_to(10, 8);
        reset_n = 1'b0;
        #1;
        check("arst_pixel_x", int'(pixel_x), 0);
        check("arst_pixel_y", int'(pixel_y), 0);
        check("arst_locked", int'(locked), 0);
        check("arst_video_on", int'(video_on), 0);
        check("arst_frame_start", int'(frame_start), 0);
        check("arst_sync_err", int'(sync_err), 0);
        repeat (3) gen_step(0);
        run_gen(4 * FRAME);
        check("arst_relock", int'(locked), 1);

        // randomized faults
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 4))
                0: f_early = 1;
                1: f_droph = 1;
                2: f_supv = 1;
                3: begin glitch_h = $urandom_range(0, HT - 1); f_glitch = 1; end
                default: repeat ($urandom_range(1, 3)) gen_step(0);
            endcase
            run_gen($urandom_range(100, 1200));
        end
        f_early = 0; f_droph = 0; f_supv = 0; f_glitch = 0;
        run_gen(5 * FRAME);
        check("random_relock", int'(locked), 1);

`ifdef VGA_DEC_ERRCNT_EN
        // 300 spurious hsync edges, each preceded by a vsync edge that re-arms checking
        for (int k = 0; k < 300; k++) begin
            drive(1, 1, 1);
            drive(1, 1, 0);
            drive(1, 1, 1);
            drive(1, 0, 1);
        end
        check("errcnt_saturate", int'(err_count), 255);
        run_gen(5 * FRAME);
        check("errcnt_relock", int'(locked), 1);
        check("errcnt_hold", int'(err_count), 255);
`endif

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
